// File: rtl/fetch_pred_pkg.sv
// Shared fetch/branch definitions: branch opcode, 2-bit counter encodings and the
// B-type immediate extractor (also used by the resolution stage's immediate generator).
package fetch_pred_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_e;

  function automatic logic signed [31:0] imm_b(input logic [31:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_pred_if.sv
// Fetch/predict bus between the fetch PC unit and its neighbours.
// Optional statistics outputs are present only when FETCH_PRED_STATS_EN is defined.
interface fetch_pred_if;
  logic        stall;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
`ifdef FETCH_PRED_STATS_EN
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  modport master (
    output stall, instr_in, instr_valid, redirect, redirect_pc,
           upd_en, upd_pc, upd_taken,
    input  pc, pred_taken, pred_target, br_count, mispred_count
  );
  modport slave (
    input  stall, instr_in, instr_valid, redirect, redirect_pc,
           upd_en, upd_pc, upd_taken,
    output pc, pred_taken, pred_target, br_count, mispred_count
  );
`else
  modport master (
    output stall, instr_in, instr_valid, redirect, redirect_pc,
           upd_en, upd_pc, upd_taken,
    input  pc, pred_taken, pred_target
  );
  modport slave (
    input  stall, instr_in, instr_valid, redirect, redirect_pc,
           upd_en, upd_pc, upd_taken,
    output pc, pred_taken, pred_target
  );
`endif
endinterface

// File: rtl/fetch_pred_bht.sv
// bht_2bit: array of 2-bit saturating direction counters, asynchronous read,
// synchronous write. A same-cycle read of the written entry returns the old value.
module bht_2bit
  import fetch_pred_pkg::*;
#(
  parameter int unsigned IDX_W    = 6,
  parameter logic [1:0]  CNT_INIT = WNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  logic [1:0] cnt_q [DEPTH];

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic taken);
    if (taken) return (c == ST)  ? ST  : c + 2'd1;
    else       return (c == SNT) ? SNT : c - 2'd1;
  endfunction

  assign rd_cnt = cnt_q[rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_INIT;
    end else if (wr_en) begin
      cnt_q[wr_idx] <= sat_step(cnt_q[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/fetch_pred.sv
// Fetch PC register, B-type predecode and 2-bit BHT direction prediction.
// Define FETCH_PRED_STATS_EN to add the br_count / mispred_count statistics outputs.
module fetch_pred
  import fetch_pred_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BHT_IDX_W = 6,
  parameter logic [1:0]  CNT_INIT  = WNT
) (
  input  logic         clk,
  input  logic         reset,
  fetch_pred_if.slave  bus
);

  logic [31:0]          pc_p0;
  logic [31:0]          pc_nxt;
  logic                 is_br;
  logic [1:0]           rd_cnt;
  logic [BHT_IDX_W-1:0] rd_idx;
  logic [BHT_IDX_W-1:0] wr_idx;
  logic signed [31:0]   br_off;
  logic                 pred_tk;
  logic [31:0]          pred_tgt;
  logic                 unused_upd_bits;

  assign unused_upd_bits = ^{bus.upd_pc[31:BHT_IDX_W+2], bus.upd_pc[1:0]};

  assign is_br    = bus.instr_valid && (bus.instr_in[6:0] == OPC_BRANCH);
  assign br_off   = imm_b(bus.instr_in);
  assign pred_tgt = pc_p0 + br_off;
  assign rd_idx   = pc_p0[BHT_IDX_W+1:2];
  assign wr_idx   = bus.upd_pc[BHT_IDX_W+1:2];
  assign pred_tk  = !reset && is_br && rd_cnt[1];

  bht_2bit #(
    .IDX_W    (BHT_IDX_W),
    .CNT_INIT (CNT_INIT)
  ) u_bht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (rd_idx),
    .rd_cnt   (rd_cnt),
    .wr_en    (bus.upd_en),
    .wr_idx   (wr_idx),
    .wr_taken (bus.upd_taken)
  );

  // Next-PC selection; redirect wins over stall so a mispredict is never lost
  always_comb begin
    pc_nxt = pc_p0 + 32'd4;
    if (reset)             pc_nxt = RESET_PC;
    else if (bus.redirect) pc_nxt = bus.redirect_pc;
    else if (bus.stall)    pc_nxt = pc_p0;
    else if (pred_tk)      pc_nxt = pred_tgt;
  end

  // Fetch PC register stage
  always_ff @(posedge clk) begin
    pc_p0 <= pc_nxt;
  end

  assign bus.pc          = pc_p0;
  assign bus.pred_taken  = pred_tk;
  assign bus.pred_target = pred_tgt;

`ifdef FETCH_PRED_STATS_EN
  logic [31:0] br_cnt_p0;
  logic [31:0] mis_cnt_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt_p0  <= '0;
      mis_cnt_p0 <= '0;
    end else if (bus.upd_en) begin
      br_cnt_p0 <= br_cnt_p0 + 32'd1;
      if (bus.redirect) mis_cnt_p0 <= mis_cnt_p0 + 32'd1;
    end
  end

  assign bus.br_count      = br_cnt_p0;
  assign bus.mispred_count = mis_cnt_p0;
`endif

endmodule

// File: tb/tb_fetch_pred.sv
// Self-checking bench for fetch_pred: directed scenarios with literal expectations,
// then randomized traffic against a behavioural model of PC sequencing and the BHT.
module tb_fetch_pred;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          NENT   = 64;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_pred_if bus();

  fetch_pred #(.RESET_PC(RST_PC), .BHT_IDX_W(6), .CNT_INIT(2'b01)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errs   = 0;
  logic [31:0] pc_m;
  int          cnt_m [NENT];
  logic [31:0] br_m, mis_m;

  // Encode a B-type branch with the given byte offset.
  function automatic logic [31:0] enc_b(input int off);
    logic [12:0] im;
    im = off[12:0];
    return {im[12], im[10:5], 5'd0, 5'd0, 3'd0, im[4:1], im[11], 7'h63};
  endfunction

  // Byte offset of a B-type word, assembled arithmetically from its fields.
  function automatic int b_offset(input logic [31:0] i);
    int off;
    off = i[31] ? -4096 : 0;
    off += i[7] ? 2048 : 0;
    off += int'(i[30:25]) * 32;
    off += int'(i[11:8]) * 2;
    return off;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic iv, input logic [31:0] ins,
                       input logic rd, input logic [31:0] rpc,
                       input logic ue, input logic [31:0] upc, input logic ut);
    bus.stall = st; bus.instr_valid = iv; bus.instr_in = ins;
    bus.redirect = rd; bus.redirect_pc = rpc;
    bus.upd_en = ue; bus.upd_pc = upc; bus.upd_taken = ut;
  endtask

  task automatic model_reset();
    pc_m = RST_PC;
    for (int i = 0; i < NENT; i++) cnt_m[i] = 1;
    br_m = 0; mis_m = 0;
  endtask

  // Compare this cycle's outputs against the model, then advance model and clock.
  task automatic step();
    logic        is_br, pt;
    logic [31:0] tgt;
    int          ui;
    #1;
    is_br = bus.instr_valid && (bus.instr_in[6:0] == 7'h63);
    tgt   = pc_m + 32'(b_offset(bus.instr_in));
    pt    = !reset && is_br && (cnt_m[(pc_m >> 2) % NENT] >= 2);
    cmp("pc", bus.pc, pc_m);
    cmp("pred_taken", {31'd0, bus.pred_taken}, {31'd0, pt});
    cmp("pred_target", bus.pred_target, tgt);
`ifdef FETCH_PRED_STATS_EN
    cmp("br_count", bus.br_count, br_m);
    cmp("mispred_count", bus.mispred_count, mis_m);
`endif
    if (reset) begin
      model_reset();
    end else begin
      if (bus.upd_en) begin
        ui = (bus.upd_pc >> 2) % NENT;
        cnt_m[ui] = bus.upd_taken ? ((cnt_m[ui] == 3) ? 3 : cnt_m[ui] + 1)
                                  : ((cnt_m[ui] == 0) ? 0 : cnt_m[ui] - 1);
        br_m = br_m + 1;
        if (bus.redirect) mis_m = mis_m + 1;
      end
      if (bus.redirect)   pc_m = bus.redirect_pc;
      else if (bus.stall) pc_m = pc_m;
      else if (pt)        pc_m = tgt;
      else                pc_m = pc_m + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] brm8;
    logic [31:0] r;
    brm8 = enc_b(-8);
    cmp("enc_model", 32'(b_offset(brm8)), 32'hFFFF_FFF8);

    // Reset held for two cycles, with a branch on the bus
    reset = 1'b1;
    drive(0, 1, brm8, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    model_reset();
    #1 cmp("pred_in_reset", {31'd0, bus.pred_taken}, 32'd0);
    step();
    cmp("reset_pc", bus.pc, 32'h100);
    reset = 1'b0;

    drive(0, 1, NOP, 0, 0, 0, 0, 0);
    step(); cmp("seq_104", bus.pc, 32'h104);
    step(); cmp("seq_108", bus.pc, 32'h108);
    step(); cmp("seq_10c", bus.pc, 32'h10C);

    drive(0, 1, NOP, 1, 32'h100, 0, 0, 0);
    step(); cmp("redir_100", bus.pc, 32'h100);

    // Cold branch: weakly not-taken
    drive(0, 1, brm8, 0, 0, 0, 0, 0);
    #1 cmp("cold_pred", {31'd0, bus.pred_taken}, 32'd0);
    cmp("cold_target", bus.pred_target, 32'hF8);
    step(); cmp("cold_next", bus.pc, 32'h104);

    // One taken update trains to weakly taken
    drive(0, 1, NOP, 0, 0, 1, 32'h100, 1);
    step();
    drive(0, 1, NOP, 1, 32'h100, 0, 0, 0);
    step();
    drive(0, 1, brm8, 0, 0, 0, 0, 0);
    #1 cmp("trained_pred", {31'd0, bus.pred_taken}, 32'd1);
    cmp("trained_target", bus.pred_target, 32'hF8);
    step(); cmp("trained_next", bus.pc, 32'hF8);

    // Two more taken (saturate at 11) then two not-taken -> 01
    drive(0, 1, NOP, 0, 0, 1, 32'h100, 1);
    step(); step();
    drive(0, 1, NOP, 0, 0, 1, 32'h100, 0);
    step(); step();
    drive(0, 1, NOP, 1, 32'h100, 0, 0, 0);
    step();
    drive(0, 1, brm8, 0, 0, 0, 0, 0);
    #1 cmp("sat_pred", {31'd0, bus.pred_taken}, 32'd0);
    step(); cmp("sat_next", bus.pc, 32'h104);

    // Priority: redirect beats stall and a taken prediction
    drive(0, 1, NOP, 1, 32'h100, 1, 32'h100, 1);
    step();
    drive(1, 1, brm8, 1, 32'h200, 0, 0, 0);
    #1 cmp("prio_pred", {31'd0, bus.pred_taken}, 32'd1);
    step(); cmp("prio_pc", bus.pc, 32'h200);

    // Stall holds pc while the BHT still trains
    drive(1, 1, NOP, 0, 0, 1, 32'h204, 1);
    for (int k = 0; k < 4; k++) begin
      step(); cmp("stall_hold", bus.pc, 32'h200);
    end
    drive(0, 1, NOP, 1, 32'h204, 0, 0, 0);
    step();
    drive(1, 1, brm8, 0, 0, 1, 32'h204, 0);
    #1 cmp("stall_trained", {31'd0, bus.pred_taken}, 32'd1);
    step();
    // Collision: lookup sees 10 while the same entry drops to 01
    #1 cmp("collide_old", {31'd0, bus.pred_taken}, 32'd1);
    step();
    drive(1, 1, brm8, 0, 0, 0, 0, 0);
    #1 cmp("collide_new", {31'd0, bus.pred_taken}, 32'd0);
    step();

    // PC wrap
    drive(0, 1, NOP, 1, 32'hFFFF_FFFC, 0, 0, 0);
    step();
    drive(0, 1, NOP, 0, 0, 0, 0, 0);
    step(); cmp("wrap_pc", bus.pc, 32'h0);

`ifdef FETCH_PRED_STATS_EN
    reset = 1'b1; step(); reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, NOP, (k < 2), 32'h300, 1, $urandom, $urandom_range(1, 0));
      step();
    end
    cmp("stats_br5", bus.br_count, 32'd5);
    cmp("stats_mis2", bus.mispred_count, 32'd2);
    reset = 1'b1; drive(0, 1, NOP, 1, 32'h40, 1, 32'h0, 1);
    step(); reset = 1'b0;
    cmp("stats_br_rst", bus.br_count, 32'd0);
    cmp("stats_mis_rst", bus.mispred_count, 32'd0);
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(63, 0) == 0);
      r = $urandom;
      if ($urandom_range(1, 0) == 1) r[6:0] = 7'h63;
      drive(($urandom_range(5, 0) == 0), ($urandom_range(9, 0) != 0), r,
            ($urandom_range(7, 0) == 0),
            ($urandom_range(7, 0) == 0) ? (32'hFFFF_FF00 | ($urandom & 32'hFC))
                                        : ($urandom & 32'h3FC),
            ($urandom_range(2, 0) == 0), $urandom, $urandom_range(1, 0));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
